// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample type, width helper and saturation used by the
// FIR stage and its downstream decimator.
package fir_pkg;

  localparam int FIR_SAMPLE_W = 16;

  typedef logic signed [FIR_SAMPLE_W-1:0] fir_sample_t;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    while ((32'd1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  // Clamps a signed value into the range of a signed width-bit number.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                       input int unsigned      width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end
    if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO with a zero-masked head output; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Boxcar decimate-by-DECIM with shift, saturation and a backpressured output FIFO.
// Define FIR_DECIM_ROUND_EN to round half-up before the shift instead of truncating.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_SAMPLE_W,
  parameter int OUT_W      = 8,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             overflow,
  output logic             drop
);

  localparam int PH_W  = clog2(DECIM);
  localparam int ACC_W = IN_W + PH_W;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [OUT_W-1:0]        stage_q, stage_d;
  logic                    stage_valid_q, stage_valid_d;
  logic                    overflow_q, overflow_d;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   scaled;
  logic signed [63:0]      scaled_w;
  logic signed [63:0]      sat_w;
  logic                    clamped;
  logic                    group_done;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign in_ext     = {{PH_W{in_data[IN_W-1]}}, in_data};
  assign sum        = acc_q + in_ext;
  assign group_done = in_valid && (phase_q == PH_W'(DECIM - 1));

  // One extra bit of headroom so the rounding offset can never wrap the sum.
`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_K = (ACC_W + 1)'(1) << (SHIFT - 1);
  assign sum_ext = {sum[ACC_W-1], sum} + ROUND_K;
`else
  assign sum_ext = {sum[ACC_W-1], sum};
`endif

  assign scaled   = sum_ext >>> SHIFT;
  assign scaled_w = {{(63 - ACC_W){scaled[ACC_W]}}, scaled};
  assign sat_w    = sat_to_width(scaled_w, OUT_W);
  assign clamped  = (sat_w != scaled_w);

  always_comb begin
    acc_d         = acc_q;
    phase_d       = phase_q;
    stage_d       = stage_q;
    stage_valid_d = 1'b0;
    overflow_d    = overflow_q;
    if (group_done) begin
      acc_d         = '0;
      phase_d       = '0;
      stage_d       = sat_w[OUT_W-1:0];
      stage_valid_d = 1'b1;
      if (clamped) begin
        overflow_d = 1'b1;
      end
    end else if (in_valid) begin
      acc_d   = sum;
      phase_d = phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q         <= '0;
      phase_q       <= '0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      phase_q       <= phase_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  fir_out_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (stage_valid_q),
    .pop_i   (out_ready),
    .din_i   (stage_q),
    .head_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Full implies non-empty, so out_ready alone tells whether a slot frees up.
  assign drop      = stage_valid_q && fifo_full && !out_ready;
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator with default parameters; expected values
// follow the rounding mode selected by FIR_DECIM_ROUND_EN.
module tb_fir_decimator;

`ifdef FIR_DECIM_ROUND_EN
  localparam int RND_POS = 1;
`else
  localparam int RND_POS = 0;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        in_valid  = 1'b0;
  logic [15:0] in_data   = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        overflow;
  logic        drop;

  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;
  int mid_seen;

  fir_decimator dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && drop === 1'b1) drop_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_group(input int v);
    for (int i = 0; i < 4; i++) send(v);
  endtask

  // Waits (bounded) for a FIFO head, checks it, then lets one edge pass for the pop.
  task automatic expect_out(input string tag, input int exp);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, $signed(out_data), exp);
    tick();
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Basic group and latency
    send_group(16);
    check("basic_lat1_valid", out_valid, 0);
    tick();
    check("basic_lat2_valid", out_valid, 1);
    check("basic_data", $signed(out_data), 4);
    check("basic_ovf", overflow, 0);
    tick();
    check("basic_popped", out_valid, 0);

    // Rounding
    send_group(2);
    expect_out("round_pos", RND_POS);
    send_group(-3);
    expect_out("round_neg", -1);
    check("round_ovf", overflow, 0);

    // Saturation
    send_group(1000);
    expect_out("sat_pos", 127);
    check("sat_pos_ovf", overflow, 1);
    send_group(-1000);
    expect_out("sat_neg", -128);
    check("sat_neg_ovf", overflow, 1);
    send_group(16);
    expect_out("sat_after", 4);
    check("sat_after_ovf", overflow, 1);

    // Gapped input
    mid_seen = 0;
    for (int i = 0; i < 4; i++) begin
      send(16);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          if (out_valid !== 1'b0) mid_seen = 1;
        end
      end
    end
    check("gap_mid", mid_seen, 0);
    expect_out("gap_data", 4);
    tick(); tick(); tick();
    check("gap_single", out_valid, 0);

    // Backpressure: fifth result dropped
    check("drop_none_yet", drop_cnt, 0);
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_group(4 * k);
    check("bp_drop_pulse", drop, 1);
    tick();
    check("bp_drop_end", drop, 0);
    check("bp_valid", out_valid, 1);
    check("bp_drop_count", drop_cnt, 1);
    out_ready = 1'b1;
    expect_out("bp_1", 1);
    expect_out("bp_2", 2);
    expect_out("bp_3", 3);
    expect_out("bp_4", 4);
    check("bp_empty", out_valid, 0);
    check("bp_empty_data", out_data, 0);

    // Full FIFO with simultaneous pop
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_group(4 * k);
    tick();
    tick();
    check("fp_full_valid", out_valid, 1);
    send_group(20);
    out_ready = 1'b1;
    #1;
    check("fp_no_drop", drop, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("fp_drop_count", drop_cnt, 1);
    send_group(24);
    check("fp_still_full", drop, 1);
    tick();
    check("fp_drop_count2", drop_cnt, 2);
    out_ready = 1'b1;
    expect_out("fp_2", 2);
    expect_out("fp_3", 3);
    expect_out("fp_4", 4);
    expect_out("fp_5", 5);
    check("fp_empty", out_valid, 0);

    // Reset in the middle of a group
    send(100);
    send(100);
    reset_n = 1'b0;
    #1;
    check("rmg_valid", out_valid, 0);
    check("rmg_data0", out_data, 0);
    check("rmg_ovf", overflow, 0);
    check("rmg_drop", drop, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_group(16);
    expect_out("rmg_data", 4);
    tick(); tick(); tick();
    check("rmg_single", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
